// File: rtl/fila_pkg.sv
// Shared types for the fila queue arbiter: FSM states, channel index and byte width.
package fila_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    GRANT        = 2'd1,
    WAIT_RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_t;

  // grant_out encoding is {B,A}
  function automatic logic [1:0] chan_onehot(chan_t ch);
    return (ch == CH_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fila_arbiter_if.sv
// Channel handshakes, queue strobe and status of the fila arbiter; slave = arbiter side.
interface fila_arbiter_if #(
  parameter int LEN_W = 8
);
  import fila_pkg::*;

  logic              data_ready_a;
  logic [DATA_W-1:0] data_a;
  logic              ack_a;
  logic              data_ready_b;
  logic [DATA_W-1:0] data_b;
  logic              ack_b;
  logic [LEN_W-1:0]  len_in;
  logic              enqueue_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant_out;
  logic              timeout_err;
  logic [DATA_W-1:0] count_a;
  logic [DATA_W-1:0] count_b;

  modport master (
    output data_ready_a, data_a, data_ready_b, data_b, len_in,
    input  ack_a, ack_b, enqueue_out, data_out, grant_out, timeout_err, count_a, count_b
  );

  modport slave (
    input  data_ready_a, data_a, data_ready_b, data_b, len_in,
    output ack_a, ack_b, enqueue_out, data_out, grant_out, timeout_err, count_a, count_b
  );

endinterface

// File: rtl/fila_arb_stats.sv
// Saturating per-channel transfer counters, built only with FILA_ARB_STATS_EN.
// One-cycle latency from the grant pulse; counters hold at 255.
module fila_arb_stats
  import fila_pkg::*;
(
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              inc_a,
  input  logic              inc_b,
  output logic [DATA_W-1:0] count_a,
  output logic [DATA_W-1:0] count_b
);

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      count_a <= '0;
      count_b <= '0;
    end else begin
      if (inc_a && (count_a != '1)) count_a <= count_a + 1'b1;
      if (inc_b && (count_b != '1)) count_b <= count_b + 1'b1;
    end
  end

endmodule

// File: rtl/fila_arbiter.sv
// Round-robin arbiter feeding one fila queue from channels A/B; strobe 2 edges after ready is sampled.
// Holds in IDLE while len_in >= DEPTH; watchdog frees a stuck channel. Counters under FILA_ARB_STATS_EN.
module fila_arbiter
  import fila_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input logic           clk_10KHz,
  input logic           reset,
  fila_arbiter_if.slave bus
);

  localparam int               WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  arb_state_t        state;
  chan_t             sel;
  chan_t             last;
  chan_t             pick;
  logic [WD_W-1:0]   wd;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        grant_q;
  logic              enq_q;
  logic              ack_a_q;
  logic              ack_b_q;
  logic              terr_q;
  logic              any_rdy;
  logic              has_room;
  logic              sel_rdy;

  assign any_rdy  = bus.data_ready_a | bus.data_ready_b;
  assign has_room = bus.len_in < DEPTH_L;
  assign sel_rdy  = (sel == CH_B) ? bus.data_ready_b : bus.data_ready_a;

  // On a tie the channel not served last wins
  always_comb begin
    pick = CH_B;
    if (bus.data_ready_a && bus.data_ready_b) pick = (last == CH_A) ? CH_B : CH_A;
    else if (bus.data_ready_a)                pick = CH_A;
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= CH_A;
      last    <= CH_B;
      wd      <= '0;
      data_q  <= '0;
      grant_q <= '0;
      enq_q   <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      enq_q   <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_rdy && has_room) begin
            sel     <= pick;
            data_q  <= (pick == CH_B) ? bus.data_b : bus.data_a;
            grant_q <= chan_onehot(pick);
            state   <= GRANT;
          end
        end
        GRANT: begin
          enq_q   <= 1'b1;
          ack_a_q <= (sel == CH_A);
          ack_b_q <= (sel == CH_B);
          last    <= sel;
          wd      <= '0;
          state   <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!sel_rdy) begin
            grant_q <= '0;
            state   <= IDLE;
          end else if (wd == WD_LAST) begin
            terr_q  <= 1'b1;
            grant_q <= '0;
            state   <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.enqueue_out = enq_q;
  assign bus.ack_a       = ack_a_q;
  assign bus.ack_b       = ack_b_q;
  assign bus.data_out    = data_q;
  assign bus.grant_out   = grant_q;
  assign bus.timeout_err = terr_q;

`ifdef FILA_ARB_STATS_EN
  logic              inc_a;
  logic              inc_b;
  logic [DATA_W-1:0] cnt_a;
  logic [DATA_W-1:0] cnt_b;

  assign inc_a = (state == GRANT) && (sel == CH_A);
  assign inc_b = (state == GRANT) && (sel == CH_B);

  fila_arb_stats u_stats (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .inc_a     (inc_a),
    .inc_b     (inc_b),
    .count_a   (cnt_a),
    .count_b   (cnt_b)
  );

  assign bus.count_a = cnt_a;
  assign bus.count_b = cnt_b;
`else
  assign bus.count_a = '0;
  assign bus.count_b = '0;
`endif

endmodule

// File: tb/tb_fila_arbiter.sv
// Directed bench for fila_arbiter: per-cycle model comparison plus literal checks of the test-plan scenarios.
module tb_fila_arbiter;
  import fila_pkg::*;

  localparam int DEPTH   = 8;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 16;

  logic clk_10KHz = 1'b0;
  logic reset;

  fila_arbiter_if #(.LEN_W(LEN_W)) bus ();

  fila_arbiter #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .bus       (bus.slave)
  );

  initial forever #50 clk_10KHz = ~clk_10KHz;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk_10KHz);
    cyc++;
  end

  typedef struct {
    int cyc;
    int d;
    int a;
    int b;
    int g;
  } strobe_t;
  strobe_t strobes[$];

  // Behavioural model: phase 0 idle, 1 granted, 2 waiting for release
  int m_phase = 0, m_wait = 0, m_sel = 0, m_last = 1;
  int m_data = 0, m_grant = 0, m_enq = 0, m_ack_a = 0, m_ack_b = 0;
  int m_terr = 0, m_cnt_a = 0, m_cnt_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_10KHz);
    #1;
  endtask

  initial begin
    int ra, rb, cur;
    forever begin
      @(posedge clk_10KHz or posedge reset);
      if (reset) begin
        m_phase = 0; m_wait = 0; m_sel = 0; m_last = 1;
        m_data = 0; m_grant = 0; m_enq = 0; m_ack_a = 0; m_ack_b = 0;
        m_terr = 0; m_cnt_a = 0; m_cnt_b = 0;
      end else begin
        ra = int'(bus.data_ready_a);
        rb = int'(bus.data_ready_b);
        m_enq = 0; m_ack_a = 0; m_ack_b = 0;
        if (m_phase == 0) begin
          if ((ra == 1 || rb == 1) && int'(bus.len_in) < DEPTH) begin
            if (ra == 1 && rb == 1) m_sel = 1 - m_last;
            else                    m_sel = (ra == 1) ? 0 : 1;
            m_data  = (m_sel == 1) ? int'(bus.data_b) : int'(bus.data_a);
            m_grant = 1 << m_sel;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_enq = 1;
          if (m_sel == 0) m_ack_a = 1; else m_ack_b = 1;
`ifdef FILA_ARB_STATS_EN
          if (m_sel == 0 && m_cnt_a < 255) m_cnt_a++;
          if (m_sel == 1 && m_cnt_b < 255) m_cnt_b++;
`endif
          m_last  = m_sel;
          m_wait  = 0;
          m_phase = 2;
        end else begin
          cur = (m_sel == 1) ? rb : ra;
          if (cur == 0) begin
            m_phase = 0; m_grant = 0;
          end else begin
            m_wait++;
            if (m_wait >= TIMEOUT) begin
              m_terr = 1; m_phase = 0; m_grant = 0;
            end
          end
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model
  initial forever begin
    @(negedge clk_10KHz);
    chk("enqueue_out", int'(bus.enqueue_out), m_enq);
    chk("ack_a", int'(bus.ack_a), m_ack_a);
    chk("ack_b", int'(bus.ack_b), m_ack_b);
    chk("data_out", int'(bus.data_out), m_data);
    chk("grant_out", int'(bus.grant_out), m_grant);
    chk("timeout_err", int'(bus.timeout_err), m_terr);
    chk("count_a", int'(bus.count_a), m_cnt_a);
    chk("count_b", int'(bus.count_b), m_cnt_b);
    if (bus.enqueue_out)
      strobes.push_back('{cyc, int'(bus.data_out), int'(bus.ack_a), int'(bus.ack_b), int'(bus.grant_out)});
  end

  // Hold ready until the matching ack, then drop it; bounded by budget
  task automatic serve(input bit want_a, input bit want_b, input int budget, input string name);
    bit pa, pb;
    int t;
    pa = want_a; pb = want_b; t = 0;
    while ((pa || pb) && t < budget) begin
      tick();
      t++;
      if (pa && bus.ack_a) begin bus.data_ready_a = 1'b0; pa = 1'b0; end
      if (pb && bus.ack_b) begin bus.data_ready_b = 1'b0; pb = 1'b0; end
    end
    checks++;
    if (pa || pb) begin
      errors++;
      $display("FAIL %s: no ack within %0d cycles, pending a=%0d b=%0d, required none pending", name, budget, pa, pb);
      bus.data_ready_a = 1'b0;
      bus.data_ready_b = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #(100 * 100000);
    $display("FAIL global_timeout: simulation still running at cycle %0d, required finished", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int k, j, n0, tcyc;
    reset = 1'b1;
    bus.data_ready_a = 1'b0;
    bus.data_ready_b = 1'b0;
    bus.data_a = '0;
    bus.data_b = '0;
    bus.len_in = '0;
    repeat (3) tick();

    chk("rst_enqueue", int'(bus.enqueue_out), 0);
    chk("rst_grant", int'(bus.grant_out), 0);
    chk("rst_data_out", int'(bus.data_out), 0);
    chk("rst_timeout_err", int'(bus.timeout_err), 0);
    reset = 1'b0;
    tick();

    // Single byte from A
    n0 = strobes.size();
    bus.data_a = 8'h5A; bus.data_ready_a = 1'b1; k = cyc;
    serve(1'b1, 1'b0, 10, "single_ack");
    repeat (3) tick();
    chk("single_strobe_count", strobes.size() - n0, 1);
    if (strobes.size() > n0) begin
      chk("single_latency", strobes[n0].cyc - k, 2);
      chk("single_data", strobes[n0].d, 'h5A);
      chk("single_ack_a", strobes[n0].a, 1);
      chk("single_ack_b", strobes[n0].b, 0);
      chk("single_grant", strobes[n0].g, 1);
    end

    // Tie right after reset: A first, then B
    reset_pulse();
    n0 = strobes.size();
    bus.data_a = 8'h11; bus.data_b = 8'h22;
    bus.data_ready_a = 1'b1; bus.data_ready_b = 1'b1; k = cyc;
    serve(1'b1, 1'b1, 20, "tie_ack");
    repeat (3) tick();
    chk("tie_strobe_count", strobes.size() - n0, 2);
    if (strobes.size() > n0 + 1) begin
      chk("tie_first_latency", strobes[n0].cyc - k, 2);
      chk("tie_first_data", strobes[n0].d, 'h11);
      chk("tie_first_ack_a", strobes[n0].a, 1);
      chk("tie_second_data", strobes[n0+1].d, 'h22);
      chk("tie_second_ack_b", strobes[n0+1].b, 1);
      chk("tie_gap_ge3", int'((strobes[n0+1].cyc - strobes[n0].cyc) >= 3), 1);
    end

    // Full queue blocks B until len_in drops below DEPTH
    n0 = strobes.size();
    bus.len_in = 8'd8;
    bus.data_b = 8'h33; bus.data_ready_b = 1'b1;
    repeat (20) tick();
    chk("full_no_strobe", strobes.size() - n0, 0);
    bus.len_in = 8'd7; j = cyc;
    serve(1'b0, 1'b1, 10, "full_ack");
    repeat (2) tick();
    chk("full_strobe_count", strobes.size() - n0, 1);
    if (strobes.size() > n0) begin
      chk("full_latency", strobes[n0].cyc - j, 2);
      chk("full_data", strobes[n0].d, 'h33);
    end
    bus.len_in = '0;
    tick();

    // Watchdog: A never releases, B waits and is served after the timeout
    n0 = strobes.size();
    bus.data_a = 8'h44; bus.data_b = 8'h55;
    bus.data_ready_a = 1'b1; bus.data_ready_b = 1'b1; k = cyc;
    tcyc = -1000;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.timeout_err) begin
        tcyc = cyc;
        break;
      end
    end
    chk("wd_fire_cycle", tcyc - k, 18);
    serve(1'b0, 1'b1, 10, "wd_b_ack");
    bus.data_ready_a = 1'b0;
    repeat (3) tick();
    chk("wd_sticky", int'(bus.timeout_err), 1);
    chk("wd_strobe_count", strobes.size() - n0, 2);
    if (strobes.size() > n0 + 1) begin
      chk("wd_a_data", strobes[n0].d, 'h44);
      chk("wd_b_data", strobes[n0+1].d, 'h55);
      chk("wd_b_latency", strobes[n0+1].cyc - k, 20);
    end

    // Reset while the strobe is high
    bus.data_a = 8'h66; bus.data_ready_a = 1'b1;
    tick();
    tick();
    chk("mid_strobe_high", int'(bus.enqueue_out), 1);
    n0 = strobes.size();
    reset = 1'b1;
    #1;
    chk("mid_enqueue_drop", int'(bus.enqueue_out), 0);
    chk("mid_ack_a_drop", int'(bus.ack_a), 0);
    chk("mid_grant_zero", int'(bus.grant_out), 0);
    chk("mid_data_zero", int'(bus.data_out), 0);
    chk("mid_terr_zero", int'(bus.timeout_err), 0);
    tick();
    reset = 1'b0;
    serve(1'b1, 1'b0, 10, "mid_ack");
    repeat (3) tick();
    chk("mid_after_count", strobes.size() - n0, 1);
    if (strobes.size() > n0) chk("mid_after_data", strobes[n0].d, 'h66);

    // Counter saturation
    reset_pulse();
    for (int i = 0; i < 300; i++) begin
      bus.data_a = 8'(i);
      bus.data_ready_a = 1'b1;
      serve(1'b1, 1'b0, 10, "stats_ack");
      tick();
    end
    repeat (2) tick();
`ifdef FILA_ARB_STATS_EN
    chk("stats_count_a", int'(bus.count_a), 255);
`else
    chk("stats_count_a", int'(bus.count_a), 0);
`endif
    chk("stats_count_b", int'(bus.count_b), 0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
